// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, opcodes,
// ALU op codes and datapath mux selects (also used by the decoder and ALU control).
package multicycle_ctrl_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned STATE_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'b001011;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  localparam logic [ALU_OP_W-1:0] ALU_NONE = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_BEQ  = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_R    = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_BNE  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 3'b101;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_LUI  = 3'b111;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_SEXT = 2'b01;
  localparam logic [1:0] SRCB_ZEXT = 2'b10;
  localparam logic [1:0] SRCB_FOUR = 2'b11;

  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  // ALU operation selected by an instruction opcode; j and unknowns use none
  function automatic logic [ALU_OP_W-1:0] alu_op_of(input logic [OP_W-1:0] op);
    logic [ALU_OP_W-1:0] r;
    r = ALU_NONE;
    case (op)
      OP_RTYPE:     r = ALU_R;
      OP_ADDI:      r = ALU_ADD;
      OP_SLTIU:     r = ALU_SLTU;
      OP_BEQ:       r = ALU_BEQ;
      OP_BNE:       r = ALU_BNE;
      OP_LUI:       r = ALU_LUI;
      OP_ORI:       r = ALU_OR;
      OP_LW, OP_SW: r = ALU_ADD;
      default:      r = ALU_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// Memory-ready wait counter: counts stalled FETCH/MEM cycles and flags the
// cycle on which the stall limit is reached without mem_ready.
module multicycle_ctrl_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam int unsigned CW = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // ready in the limit cycle wins over the abort
  assign timeout_o = active_i && !ready_i && (cnt_q == CW'(WAIT_MAX - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!active_i || ready_i || timeout_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB/BRANCH/JUMP.
// Optional MULTICYCLE_CTRL_RETIRE_CNT_EN adds the retired-instruction counter retired_o.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [OP_W-1:0]     instr_op_i,
  input  logic                zero_i,
  input  logic                mem_ready_i,
  output logic                pc_write_o,
  output logic                ir_write_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                i_or_d_o,
  output logic                reg_write_o,
  output logic                reg_dst_o,
  output logic                mem_to_reg_o,
  output logic                alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic [1:0]          pc_src_o,
  output logic [STATE_W-1:0]  state_o,
  output logic                illegal_o,
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  output logic [CNT_W-1:0]    retired_o,
`endif
  output logic                err_o
);

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            illegal_q, illegal_d;
  logic            err_q, err_d;
  logic            wait_active_c;
  logic            timeout_c;
  logic            pc_write_c, ir_write_c, mem_write_c, reg_write_c;

  multicycle_ctrl_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .active_i  (wait_active_c),
    .ready_i   (mem_ready_i),
    .timeout_o (timeout_c)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    illegal_d     = illegal_q;
    err_d         = err_q;
    wait_active_c = 1'b0;
    pc_write_c    = 1'b0;
    ir_write_c    = 1'b0;
    mem_write_c   = 1'b0;
    reg_write_c   = 1'b0;
    mem_read_o    = 1'b0;
    i_or_d_o      = 1'b0;
    reg_dst_o     = 1'b0;
    mem_to_reg_o  = 1'b0;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = SRCB_RT;
    alu_op_o      = ALU_NONE;
    pc_src_o      = PCSRC_ALU;
    case (state_q)
      S_FETCH: begin
        mem_read_o    = 1'b1;
        alu_src_b_o   = SRCB_FOUR;
        alu_op_o      = ALU_ADD;
        wait_active_c = 1'b1;
        if (mem_ready_i) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (timeout_c) begin
          err_d = 1'b1;
        end
      end
      S_DECODE: begin
        op_d = instr_op_i;
        case (instr_op_i)
          OP_RTYPE, OP_ADDI, OP_SLTIU, OP_LUI,
          OP_ORI, OP_LW, OP_SW:  state_d = S_EXEC;
          OP_BEQ, OP_BNE:        state_d = S_BRANCH;
          OP_J:                  state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = alu_op_of(op_q);
        case (op_q)
          OP_ADDI, OP_LW, OP_SW: alu_src_b_o = SRCB_SEXT;
          OP_SLTIU, OP_ORI:      alu_src_b_o = SRCB_ZEXT;
          default:               alu_src_b_o = SRCB_RT;
        endcase
        state_d = ((op_q == OP_LW) || (op_q == OP_SW)) ? S_MEM : S_WB;
      end
      S_MEM: begin
        i_or_d_o      = 1'b1;
        wait_active_c = 1'b1;
        mem_read_o    = (op_q == OP_LW);
        mem_write_c   = (op_q == OP_SW) && !timeout_c;
        if (mem_ready_i) begin
          state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
        end else if (timeout_c) begin
          err_d   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        reg_write_c  = 1'b1;
        reg_dst_o    = (op_q == OP_RTYPE);
        mem_to_reg_o = (op_q == OP_LW);
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = alu_op_of(op_q);
        pc_src_o    = PCSRC_BR;
        pc_write_c  = ((op_q == OP_BEQ) && zero_i) || ((op_q == OP_BNE) && !zero_i);
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_write_c = 1'b1;
        pc_src_o   = PCSRC_JMP;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      err_q     <= err_d;
    end
  end

  // write strobes are held off for the whole reset pulse
  assign pc_write_o  = pc_write_c  & ~rst_i;
  assign ir_write_o  = ir_write_c  & ~rst_i;
  assign mem_write_o = mem_write_c & ~rst_i;
  assign reg_write_o = reg_write_c & ~rst_i;
  assign state_o     = state_q;
  assign illegal_o   = illegal_q;
  assign err_o       = err_q;

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  logic             retire_c;
  logic [CNT_W-1:0] retired_q, retired_d;

  // completed instructions only; illegal and timeout aborts never get here
  assign retire_c = (state_q == S_WB) || (state_q == S_BRANCH) || (state_q == S_JUMP) ||
                    ((state_q == S_MEM) && mem_ready_i && (op_q == OP_SW));

  always_comb begin
    retired_d = retired_q;
    if (retire_c) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired_o = retired_q;
`endif

endmodule
